// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART constants, tx state encoding and baud helper.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int ticks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                               |
// | Description : Bit-time counter; Tick_o marks the last cycle of a bit.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int TICKS = 10
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear_i,
    output logic Tick_o
);

    localparam int                  c_cnt_w = $clog2(TICKS);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TICKS - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (Reset || Clear_i) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign Tick_o = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx                                                      |
// | Description : UART transmitter, 8 data bits LSB first, opt. parity, 1/2 SB.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 10_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start_i,
    input  logic [7:0] Data_i,
    output logic       Busy_o,
    output logic       Done_o,
    output logic       Tx_o
);

    localparam int   c_ticks_per_bit = ticks_per_bit(CLOCK_HZ, BAUD);
    localparam logic c_stop_last     = (STOP_BITS == 2);
    localparam logic c_parity_en     = (PARITY != UART_PARITY_NONE);
    localparam logic c_parity_odd    = (PARITY == UART_PARITY_ODD);

    generate
        if (PARITY != UART_PARITY_NONE && PARITY != UART_PARITY_ODD &&
            PARITY != UART_PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (c_ticks_per_bit < 2) begin : g_bad_baud
            $error("uart_tx: CLOCK_HZ / BAUD must be at least 2");
        end
    endgenerate

    tx_state_t  r_state, w_state_next;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic       r_stop_cnt, w_stop_cnt_next;
    logic       r_parity, w_parity_next;
    logic       r_tx, w_tx_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;
    logic       w_tick;
    logic       w_clear;

    // Counter is held in idle so the start bit begins a fresh bit time on accept
    assign w_clear = (r_state == TX_IDLE);

    uart_baud_tick #(
        .TICKS (c_ticks_per_bit)
    ) u_baud_tick (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear_i (w_clear),
        .Tick_o  (w_tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // Next line level is computed here so Tx_o always comes straight from r_tx
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_parity_next   = r_parity;
        w_tx_next       = r_tx;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (Start_i) begin
                    w_state_next   = TX_START;
                    w_shift_next   = Data_i;
                    w_parity_next  = (^Data_i) ^ c_parity_odd;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = 1'b0;
                    w_busy_next    = 1'b1;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    w_state_next   = TX_DATA;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        if (c_parity_en) begin
                            w_state_next = TX_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next    = TX_STOP;
                            w_stop_cnt_next = 1'b0;
                            w_tx_next       = 1'b1;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tick) begin
                    w_state_next    = TX_STOP;
                    w_stop_cnt_next = 1'b0;
                    w_tx_next       = 1'b1;
                end
            end
            TX_STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_stop_cnt == c_stop_last) begin
                        w_state_next = TX_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = TX_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign Tx_o   = r_tx;
    assign Busy_o = r_busy;
    assign Done_o = r_done;

endmodule

`default_nettype wire
